// File: rtl/instr_mem_loader_pkg.sv
// Shared types and helpers for the instruction assembler/loader: op classes, RV32I major
// opcodes, loader FSM states, field packing and opcode legality.
package instr_mem_loader_pkg;

    localparam int INSTRUCTION_WIDTH             = 32;
    localparam int PROGRAM_ADDRESS_WIDTH_DEFAULT = 6;

    typedef enum logic [2:0] {
        OPT_R   = 3'd0,
        OPT_I   = 3'd1,
        OPT_S   = 3'd2,
        OPT_B   = 3'd3,
        OPT_U   = 3'd4,
        OPT_J   = 3'd5,
        OPT_SYS = 3'd6
    } instruction_op_type;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_LOAD_FP  = 7'h07,
        OPC_OP_IMM   = 7'h13,
        OPC_U_AUIPC  = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_STORE_FP = 7'h27,
        OPC_OP       = 7'h33,
        OPC_U_LUI    = 7'h37,
        OPC_MADD     = 7'h43,
        OPC_MSUB     = 7'h47,
        OPC_NMSUB    = 7'h4B,
        OPC_NMADD    = 7'h4F,
        OPC_OP_FP    = 7'h53,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_J_JAL    = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } instruction_format_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // An out-of-range op_type has no legal opcode, so it is rejected here as well.
    function automatic logic opcode_legal(input logic [2:0] op_type, input logic [6:0] opcode);
        logic ok;
        ok = 1'b0;
        case (op_type)
            OPT_R:   ok = opcode inside {OPC_OP, OPC_OP_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD};
            OPT_I:   ok = opcode inside {OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_LOAD_FP};
            OPT_S:   ok = opcode inside {OPC_STORE, OPC_STORE_FP};
            OPT_B:   ok = (opcode == OPC_BRANCH);
            OPT_U:   ok = opcode inside {OPC_U_AUIPC, OPC_U_LUI};
            OPT_J:   ok = (opcode == OPC_J_JAL);
            OPT_SYS: ok = (opcode == OPC_SYSTEM);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [INSTRUCTION_WIDTH-1:0] encode_word(
        input logic [2:0]  op_type,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        logic [INSTRUCTION_WIDTH-1:0] w;
        w = '0;
        case (op_type)
            OPT_R:          w = {funct7, rs2, rs1, funct3, rd, opcode};
            OPT_I, OPT_SYS: w = {imm[11:0], rs1, funct3, rd, opcode};
            OPT_S:          w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            OPT_B:          w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            OPT_U:          w = {imm[31:12], rd, opcode};
            OPT_J:          w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default:        w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Field-set stream, session control/status and instruction-memory write port of the loader.
interface instr_mem_loader_if
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = PROGRAM_ADDRESS_WIDTH_DEFAULT
);
    logic                         start;
    logic [ADDR_WIDTH-1:0]        base_addr;
    logic                         op_valid;
    logic                         op_ready;
    logic                         op_last;
    logic [2:0]                   op_type;
    logic [6:0]                   opcode;
    logic [4:0]                   rd;
    logic [4:0]                   rs1;
    logic [4:0]                   rs2;
    logic [2:0]                   funct3;
    logic [6:0]                   funct7;
    logic [31:0]                  imm;
    logic                         mem_we;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [INSTRUCTION_WIDTH-1:0] mem_wdata;
    logic                         busy;
    logic                         done;
    logic                         full;
    logic                         err;
    logic [ADDR_WIDTH:0]          words_written;

    modport slave (
        input  start, base_addr, op_valid, op_last, op_type, opcode,
               rd, rs1, rs2, funct3, funct7, imm,
        output op_ready, mem_we, mem_addr, mem_wdata,
               busy, done, full, err, words_written
    );

    modport master (
        output start, base_addr, op_valid, op_last, op_type, opcode,
               rd, rs1, rs2, funct3, funct7, imm,
        input  op_ready, mem_we, mem_addr, mem_wdata,
               busy, done, full, err, words_written
    );
endinterface

// File: rtl/instr_mem_loader_encoder.sv
// Combinational RV32I field packer; also flags field sets that cannot be encoded legally.
module instr_encoder
    import instr_mem_loader_pkg::*;
(
    input  logic [2:0]                   op_type,
    input  logic [6:0]                   opcode,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [2:0]                   funct3,
    input  logic [6:0]                   funct7,
    input  logic [31:0]                  imm,
    output logic [INSTRUCTION_WIDTH-1:0] word,
    output logic                         reject
);
    logic misaligned;

    always_comb begin
        word       = encode_word(op_type, opcode, rd, rs1, rs2, funct3, funct7, imm);
        // Branch/jump offsets are halfword multiples; bit 0 has no slot in the encoding.
        misaligned = ((op_type == OPT_B) || (op_type == OPT_J)) && imm[0];
        reject     = misaligned || !opcode_legal(op_type, opcode);
    end
endmodule

// File: rtl/instr_mem_loader.sv
// Session FSM and one-stage write pipeline: accepted field sets are encoded and written
// to sequential instruction-memory addresses the cycle after their handshake.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int PROGRAM_ADDRESS_WIDTH = PROGRAM_ADDRESS_WIDTH_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    instr_mem_loader_if.slave bus
);
    localparam int AW = PROGRAM_ADDRESS_WIDTH;
    localparam logic [AW-1:0] TOP_ADDR = {AW{1'b1}};

    loader_state_t                state_reg, state_next;
    logic [AW-1:0]                wr_ptr_reg;
    logic [AW:0]                  words_reg;
    logic                         pend_valid_reg;
    logic [INSTRUCTION_WIDTH-1:0] pend_word_reg;
    logic                         full_reg;
    logic                         err_reg;

    logic [INSTRUCTION_WIDTH-1:0] enc_word;
    logic                         enc_reject;
    logic                         handshake;
    logic                         accept;
    logic                         hit_top;
    logic [AW-1:0]                target_addr;

    instr_encoder u_encoder (
        .op_type (bus.op_type),
        .opcode  (bus.opcode),
        .rd      (bus.rd),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .funct3  (bus.funct3),
        .funct7  (bus.funct7),
        .imm     (bus.imm),
        .word    (enc_word),
        .reject  (enc_reject)
    );

    always_comb begin
        state_next  = state_reg;
        handshake   = (state_reg == LOAD) && bus.op_valid;
        accept      = handshake && !enc_reject;
        // A word still in the pipeline owns wr_ptr, so a new word lands one slot later.
        target_addr = wr_ptr_reg + AW'(pend_valid_reg);
        hit_top     = accept && (target_addr == TOP_ADDR);
        case (state_reg)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    if (handshake && (bus.op_last || hit_top)) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            words_reg      <= '0;
            pend_valid_reg <= 1'b0;
            pend_word_reg  <= '0;
            full_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pend_valid_reg <= accept;
            if (accept) begin
                pend_word_reg <= enc_word;
            end
            if ((state_reg == IDLE) && bus.start) begin
                wr_ptr_reg <= bus.base_addr;
                words_reg  <= '0;
                full_reg   <= 1'b0;
                err_reg    <= 1'b0;
            end else begin
                if (pend_valid_reg) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    words_reg  <= words_reg + 1'b1;
                end
                if (hit_top) begin
                    full_reg <= 1'b1;
                end
                if (handshake && enc_reject) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.op_ready      = (state_reg == LOAD);
    assign bus.mem_we        = pend_valid_reg;
    assign bus.mem_addr      = wr_ptr_reg;
    assign bus.mem_wdata     = pend_word_reg;
    assign bus.busy          = (state_reg == LOAD) || (state_reg == DRAIN);
    assign bus.done          = (state_reg == DONE);
    assign bus.full          = full_reg;
    assign bus.err           = err_reg;
    assign bus.words_written = words_reg;
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Instruction assembler and program-memory writer, the encode side of the core's decode path. It accepts instruction fields (format class, opcode, register indices, funct, immediate) over a valid/ready stream. It packs each field set into a 32-bit RV32I instruction word and writes it sequentially into the instruction memory's write port. Used by the boot/test harness to load programs before the core leaves reset.

Parameters:
INSTRUCTION_WIDTH, 32, instruction word width (from common package)
PROGRAM_ADDRESS_WIDTH, 6, instruction memory address width; depth = 2**PROGRAM_ADDRESS_WIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse; latches base_addr and begins a load session (IDLE only)
base_addr  in  PROGRAM_ADDRESS_WIDTH  first word address of the session
op_valid  in  1  field set valid
op_ready  out  1  loader can accept a field set this cycle
op_last  in  1  qualifies the final field set of the program
op_type  in  3  instruction_op_type (R/I/S/B/U/J/SYS)
opcode  in  7  instruction_format_type value, placed verbatim in bits [6:0]
rd, rs1, rs2  in  5 each  register indices
funct3  in  3  funct3
funct7  in  7  funct7 (R only)
imm  in  32  immediate, byte-offset form for B/J, full value for U (imm[31:12] used)
mem_we  out  1  instruction memory write enable
mem_addr  out  PROGRAM_ADDRESS_WIDTH  write address
mem_wdata  out  32  encoded instruction word
busy  out  1  session active (LOAD or DRAIN)
done  out  1  one-cycle pulse at session end
full  out  1  sticky: session ended because the top address was written
err  out  1  sticky: at least one field set was rejected
words_written  out  PROGRAM_ADDRESS_WIDTH+1  count of words written this session

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE; all outputs 0; the write pipeline is flushed. Reset mid-session aborts it with no further writes.
- FSM states:
  - IDLE: start -> LOAD; wr_ptr<=base_addr; words_written, full, err <= 0.
  - LOAD: op_ready=1. On a handshake (op_valid & op_ready), encode the field set into the pipeline register.
    - Handshake with op_last -> DRAIN.
    - Handshake that writes address 2**PROGRAM_ADDRESS_WIDTH-1 -> DRAIN and sets full.
  - DRAIN: op_ready=0; wait one cycle for the final write -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start is ignored outside IDLE.
- Latency: handshake in cycle N -> mem_we=1 with mem_addr/mem_wdata in cycle N+1. Throughput is 1 word/cycle. wr_ptr and words_written increment at the write.
- Encoding (bits high..low):
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I and SYS: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Rejection rules:
  - A field set is rejected (handshake completes, no write, no pointer advance, err set) when:
    - B or J has imm[0]=1;
    - op_type is not one of the 7 enum values;
    - opcode does not belong to op_type per the instruction_format_type grouping. R: OP, OP_FP, MADD, MSUB, NMSUB, NMADD. I: OP_IMM, JALR, LOAD, LOAD_FP. S: STORE, STORE_FP. B: BRANCH. U: U_AUIPC, U_LUI. J: J_JAL. SYS: SYSTEM.
  - A rejected set carrying op_last still ends the session.
- Immediate range is not checked; out-of-range bits are truncated.
- Wrap-around: the address never wraps. Reaching the top address ends the session via full, even if op_last was not seen.
- The same-cycle op_last and top-address case sets full and ends once.

Decomposition:
- The common package is extended with:
  - the encode function or its bit-slice localparams;
  - an opcode-to-op_type legality function;
  - typedef loader_state_t {IDLE, LOAD, DRAIN, DONE}.
- The existing instruction_op_type and instruction_format_type enums are reused unchanged.
- One combinational sub-module, instr_encoder: fields in, word out plus a reject flag. This lets the decoder bench reuse it as a golden model.

Test Plan:
- ADDI x1,x0,5 (I, opcode 0010011, rd=1, imm=5) with base_addr=0 -> cycle+1: mem_we=1, addr 0, wdata 0x00500093.
- Stream with no gaps, last flagged on the final set: ADD x3,x1,x2 -> 0x002081B3; SW x2,8(x1) -> 0x0020A423; BEQ x1,x2,+8 -> 0x00208463; LUI x5,0x12345 -> 0x123452B7; JAL x1,+16 -> 0x010000EF. Expect addresses 0..4 on consecutive cycles, words_written=5, done pulse, full=0, err=0.
- Rejection:
  - BEQ with imm=7 -> no write, err=1, next valid op uses the same address.
  - op_type=R with opcode=BRANCH -> rejected.
- Overflow: base_addr=62, three ops without last -> writes at 62 and 63, full=1, done. op_ready drops after the second handshake; the third op is never accepted.
- Mid-session reset: after 2 writes assert reset -> next cycle mem_we=0, busy=0, state IDLE. A new start re-zeroes words_written.
- start pulsed while busy -> ignored. base_addr and wr_ptr are unchanged.
